// File: rtl/jtag_led_pkg.sv
// rtl/jtag_led_pkg.sv - opcodes and status layout for the ER1 LED FIFO chain
//
// Purpose: shared definitions for jtag_led_fifo_chain and its FIFO.
//   op_e              : command opcode carried in the two MSBs of the shift word
//   ST_*_OFS          : status flag positions, counted upward from the level field

package jtag_led_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_PUSH  = 2'b01,
      OP_FLUSH = 2'b10,
      OP_POP   = 2'b11
   } op_e;

   // Status word = {ovf, udf, full, empty, level}; level occupies the LSBs and
   // the flags sit directly above it, so their absolute position depends on
   // the level width of the instance.
   localparam int ST_EMPTY_OFS = 0;
   localparam int ST_FULL_OFS  = 1;
   localparam int ST_UDF_OFS   = 2;
   localparam int ST_OVF_OFS   = 3;
   localparam int ST_FLAG_W    = 4;

endpackage

// File: rtl/jtag_led_fifo.sv
// rtl/jtag_led_fifo.sv - single-clock DEPTH x DATA_W pattern FIFO
//
// Purpose: buffers LED patterns between the JTAG decode and playback.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   push_i, wdata_i   : write request and data
//   pop_i             : read request (head advances)
//   flush_i           : empty the FIFO; overrides push and pop
//   head_o            : oldest entry (valid when !empty_o)
//   level_o           : registered entry count
//   full_o, empty_o   : level == DEPTH / level == 0

module jtag_led_fifo
   import jtag_led_pkg::*;
#(
   parameter  int DATA_W = 9,
   parameter  int DEPTH  = 8,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] head_o,
   output logic [LVL_W-1:0]  level_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              do_push, do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push onto a full FIFO is still taken when a pop frees a slot this edge.
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: entries are only read below the level count.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/jtag_led_fifo_chain.sv
// rtl/jtag_led_fifo_chain.sv - ER1 JTAG data register feeding an LED pattern FIFO
//
// Purpose: JTCK-clocked ER1 chain; shifts in {op, data} words, buffers LED
// patterns and plays them out while the TAP idles in Run-Test/Idle.
// Ports:
//   JTCK, JRSTN        : JTAG clock, asynchronous active-low reset
//   JTDI, JTD1         : serial in / serial out (JTD1 = sr[0])
//   JSHIFT, JCE1       : Capture-DR (JCE1 & !JSHIFT) and Shift-DR (JCE1 & JSHIFT)
//   JUPDATE            : Update-DR, shared by every chain
//   JRTI1              : Run-Test/Idle with ER1 loaded; drives playback
//   LEDS               : current LED pattern (registered)
//   fifo_level         : FIFO entry count (registered)

module jtag_led_fifo_chain
   import jtag_led_pkg::*;
#(
   parameter int DATA_W  = 9,
   parameter int DEPTH   = 8,
   parameter int RTI_DIV = 4
) (
   input  logic                       JTCK,
   input  logic                       JRSTN,
   input  logic                       JTDI,
   input  logic                       JSHIFT,
   input  logic                       JUPDATE,
   input  logic                       JCE1,
   input  logic                       JRTI1,
   output logic                       JTD1,
   output logic [DATA_W-1:0]          LEDS,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

   localparam int SR_W  = DATA_W + 2;
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int CNT_W = (RTI_DIV > 1) ? $clog2(RTI_DIV) : 1;

   logic [SR_W-1:0]   sr_q, sr_d;
   logic              armed_q, armed_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic [CNT_W-1:0]  rti_cnt_q, rti_cnt_d;
   logic [DATA_W-1:0] leds_q, leds_d;

   logic              capture, shift, update;
   op_e               op;
   logic              cmd_push, cmd_pop, cmd_flush;
   logic              rti_term, play_pop, fifo_pop;
   logic [SR_W-1:0]   status;

   logic [DATA_W-1:0] fifo_head;
   logic [LVL_W-1:0]  fifo_lvl;
   logic              fifo_full, fifo_empty;

   assign capture = JCE1 & ~JSHIFT;
   assign shift   = JCE1 & JSHIFT;
   // Only a word this chain actually shifted may be decoded; JUPDATE alone
   // belongs to whichever chain the TAP last scanned.
   assign update  = JUPDATE & armed_q;

   assign op        = op_e'(sr_q[SR_W-1 -: 2]);
   assign cmd_push  = update && (op == OP_PUSH);
   assign cmd_pop   = update && (op == OP_POP);
   assign cmd_flush = update && (op == OP_FLUSH);

   assign rti_term = JRTI1 && (rti_cnt_q == CNT_W'(RTI_DIV - 1));
   assign play_pop = rti_term & ~fifo_empty & ~cmd_flush;
   assign fifo_pop = cmd_pop | play_pop;

   always_comb begin
      status                           = '0;
      status[LVL_W-1:0]                = fifo_lvl;
      status[LVL_W + ST_EMPTY_OFS]     = fifo_empty;
      status[LVL_W + ST_FULL_OFS]      = fifo_full;
      status[LVL_W + ST_UDF_OFS]       = udf_q;
      status[LVL_W + ST_OVF_OFS]       = ovf_q;
   end

   always_comb begin
      sr_d      = sr_q;
      armed_d   = armed_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      rti_cnt_d = rti_cnt_q;
      leds_d    = leds_q;

      if (capture) begin
         sr_d    = status;
         armed_d = 1'b0;
      end else if (shift) begin
         sr_d    = {JTDI, sr_q[SR_W-1:1]};
         armed_d = 1'b1;
      end
      if (update) armed_d = 1'b0;

      if (cmd_flush) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end else begin
         // Full implies non-empty, so any pop this edge makes room.
         if (cmd_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
         if (cmd_pop && fifo_empty)               udf_d = 1'b1;
      end

      if (fifo_pop && !fifo_empty) leds_d = fifo_head;

      if (cmd_flush || !JRTI1 || rti_term) rti_cnt_d = '0;
      else                                  rti_cnt_d = rti_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge JTCK or negedge JRSTN) begin
      if (!JRSTN) begin
         sr_q      <= '0;
         armed_q   <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         rti_cnt_q <= '0;
         leds_q    <= '0;
      end else begin
         sr_q      <= sr_d;
         armed_q   <= armed_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         rti_cnt_q <= rti_cnt_d;
         leds_q    <= leds_d;
      end
   end

   jtag_led_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i   (JTCK),
      .rst_ni  (JRSTN),
      .push_i  (cmd_push),
      .pop_i   (fifo_pop),
      .flush_i (cmd_flush),
      .wdata_i (sr_q[DATA_W-1:0]),
      .head_o  (fifo_head),
      .level_o (fifo_lvl),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign JTD1       = sr_q[0];
   assign LEDS       = leds_q;
   assign fifo_level = fifo_lvl;

endmodule
